// File: rtl/cart_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cart_bus_pkg
// Purpose : Shared types and address map for the cartridge bus master.
//           Defines the bus-cycle state enum, the registered request
//           record and Game Boy cartridge address-window helpers.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cart_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [15:0] ROM_BANK0_END = 16'h3FFF;
  localparam logic [15:0] ROM_END       = 16'h7FFF;
  localparam logic [15:0] BANK_SEL_LO   = 16'h2000;
  localparam logic [15:0] BANK_SEL_HI   = 16'h3FFF;
  localparam logic [15:0] SRAM_LO       = 16'hA000;
  localparam logic [15:0] SRAM_HI       = 16'hBFFF;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cart_req_t;

  // External cartridge RAM window: the only range that selects /CS.
  function automatic logic in_sram(input logic [15:0] addr);
    return (addr >= SRAM_LO) && (addr <= SRAM_HI);
  endfunction

  // MBC ROM bank-select register window.
  function automatic logic in_bank_sel(input logic [15:0] addr);
    return (addr >= BANK_SEL_LO) && (addr <= BANK_SEL_HI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cart_bus_phase_timer.sv
`default_nettype none
// ============================================================================
// Module  : cart_bus_phase_timer
// Purpose : Phase-length down counter. A load sets the count to
//           PHASE_CLKS-1; it then counts down and holds at zero. done is
//           high while the count is zero, i.e. in the last cycle of a phase.
// Ports   : clk  - clock
//           rst  - asynchronous active-low reset
//           load - start a new phase (count <= PHASE_CLKS-1)
//           done - current cycle is the last of the phase
// Revision: 1.0 - initial release
// ============================================================================
module cart_bus_phase_timer #(
  parameter int unsigned PHASE_CLKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (load) begin
      count <= 8'(PHASE_CLKS - 1);
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign done = (count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/cart_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : cart_bus_master
// Purpose : Initiator side of the Game Boy cartridge bus. Turns one
//           single-beat host request at a time into a SETUP/STROBE/HOLD bus
//           cycle (PHASE_CLKS clocks each) followed by a one-cycle response.
//           All bus outputs are registered from the next-state decode.
// Config  : CART_BUS_MASTER_BANK_SHADOW_EN adds bank_shadow[4:0], a copy of
//           the last completed write to 0x2000-0x3FFF (0 stored as 1).
// Ports   : clk, rst (async active-low)
//           req_valid/req_ready/req_we/req_addr/req_wdata - host request
//           rsp_valid/rsp_rdata - completion pulse and read data
//           cart_addr, cart_data_out/oe/in, cart_rd_n, cart_wr_n,
//           cart_cs_n, cart_clk - cartridge bus
// Revision: 1.0 - initial release
// ============================================================================
module cart_bus_master
  import cart_bus_pkg::*;
#(
  parameter int unsigned PHASE_CLKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] cart_addr,
  output logic [7:0]  cart_data_out,
  output logic        cart_data_oe,
  input  logic [7:0]  cart_data_in,
  output logic        cart_rd_n,
  output logic        cart_wr_n,
  output logic        cart_cs_n,
  output logic        cart_clk
`ifdef CART_BUS_MASTER_BANK_SHADOW_EN
  ,
  output logic [4:0]  bank_shadow
`endif
);

  state_t    state, state_next;
  cart_req_t req_r, cur;
  logic      load, done, busy_next;
  logic [7:0] rd_cap;

  cart_bus_phase_timer #(.PHASE_CLKS(PHASE_CLKS)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .done (done)
  );

  assign req_ready = (state == IDLE);

  // In IDLE the outputs for the first SETUP cycle must come from the live
  // request, since req_r is only written at the accepting edge.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    cur        = req_r;
    if (state == IDLE) begin
      cur.we    = req_we;
      cur.addr  = req_addr;
      cur.wdata = req_wdata;
    end
    case (state)
      IDLE:   if (req_valid) begin state_next = SETUP;  load = 1'b1; end
      SETUP:  if (done)      begin state_next = STROBE; load = 1'b1; end
      STROBE: if (done)      begin state_next = HOLD;   load = 1'b1; end
      HOLD:   if (done)            state_next = RESP;
      RESP:                        state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  assign busy_next = (state_next == SETUP) || (state_next == STROBE) ||
                     (state_next == HOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      req_r         <= '0;
      rd_cap        <= 8'd0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 8'd0;
      cart_addr     <= 16'd0;
      cart_data_out <= 8'd0;
      cart_data_oe  <= 1'b0;
      cart_rd_n     <= 1'b1;
      cart_wr_n     <= 1'b1;
      cart_cs_n     <= 1'b1;
      cart_clk      <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        req_r <= cur;
      end
      cart_addr     <= busy_next ? cur.addr : 16'd0;
      cart_cs_n     <= !(busy_next && in_sram(cur.addr));
      cart_rd_n     <= !(!cur.we && (state_next == SETUP || state_next == STROBE));
      cart_wr_n     <= !(cur.we && state_next == STROBE);
      cart_data_oe  <= busy_next && cur.we;
      cart_data_out <= (busy_next && cur.we) ? cur.wdata : 8'd0;
      cart_clk      <= (state_next == STROBE);
      rsp_valid     <= (state_next == RESP);
      // Sample the bus at the end of STROBE, but only publish it together
      // with rsp_valid so rsp_rdata stays stable between responses.
      if (state == STROBE && done) begin
        rd_cap <= req_r.we ? 8'd0 : cart_data_in;
      end
      if (state == HOLD && done) begin
        rsp_rdata <= rd_cap;
      end
    end
  end

`ifdef CART_BUS_MASTER_BANK_SHADOW_EN
  // Updated on the edge leaving RESP, so visible the cycle after rsp_valid.
  // Bank 0 maps to bank 1 exactly as the MBC register does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_shadow <= 5'd1;
    end else if (state == RESP && req_r.we && in_bank_sel(req_r.addr)) begin
      bank_shadow <= (req_r.wdata[4:0] == 5'd0) ? 5'd1 : req_r.wdata[4:0];
    end
  end
`else
  // Bank shadow register not present in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_cart_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_cart_bus_master
// Purpose : Self-checking bench for cart_bus_master (PHASE_CLKS=4 main
//           instance, PHASE_CLKS=1 secondary instance). A transaction-level
//           model tracks the cycle offset since acceptance and derives every
//           bus output from it; directed tests add literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cart_bus_master;

  localparam int P        = 4;
  localparam int RESP_OFF = 3 * P + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [15:0] req_addr = 16'd0;
  logic [7:0]  req_wdata = 8'd0;
  logic        req_ready, rsp_valid, cart_data_oe, cart_rd_n, cart_wr_n, cart_cs_n, cart_clk;
  logic [7:0]  rsp_rdata, cart_data_out, cart_data_in;
  logic [15:0] cart_addr;
`ifdef CART_BUS_MASTER_BANK_SHADOW_EN
  logic [4:0]  bank_shadow;
`endif

  logic        req_valid_1 = 1'b0, req_we_1 = 1'b0;
  logic [15:0] req_addr_1 = 16'd0;
  logic [7:0]  req_wdata_1 = 8'd0;
  logic        req_ready_1, rsp_valid_1, cart_data_oe_1, cart_rd_n_1, cart_wr_n_1, cart_cs_n_1, cart_clk_1;
  logic [7:0]  rsp_rdata_1, cart_data_out_1, cart_data_in_1;
  logic [15:0] cart_addr_1;
`ifdef CART_BUS_MASTER_BANK_SHADOW_EN
  logic [4:0]  bank_shadow_1;
`endif

  cart_bus_master #(.PHASE_CLKS(P)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cart_addr(cart_addr), .cart_data_out(cart_data_out), .cart_data_oe(cart_data_oe),
    .cart_data_in(cart_data_in), .cart_rd_n(cart_rd_n), .cart_wr_n(cart_wr_n),
    .cart_cs_n(cart_cs_n), .cart_clk(cart_clk)
`ifdef CART_BUS_MASTER_BANK_SHADOW_EN
    , .bank_shadow(bank_shadow)
`endif
  );

  cart_bus_master #(.PHASE_CLKS(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid_1), .req_ready(req_ready_1), .req_we(req_we_1),
    .req_addr(req_addr_1), .req_wdata(req_wdata_1), .rsp_valid(rsp_valid_1), .rsp_rdata(rsp_rdata_1),
    .cart_addr(cart_addr_1), .cart_data_out(cart_data_out_1), .cart_data_oe(cart_data_oe_1),
    .cart_data_in(cart_data_in_1), .cart_rd_n(cart_rd_n_1), .cart_wr_n(cart_wr_n_1),
    .cart_cs_n(cart_cs_n_1), .cart_clk(cart_clk_1)
`ifdef CART_BUS_MASTER_BANK_SHADOW_EN
    , .bank_shadow(bank_shadow_1)
`endif
  );

  // Cartridge contents seen by the responder: 0x0150 -> 8'h3C.
  function automatic logic [7:0] rom_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h6D;
  endfunction

  // Slow responder: data is only valid in the last cycle of the strobe.
  int scnt = 0;
  always @(posedge clk) scnt <= cart_clk ? scnt + 1 : 0;
  assign cart_data_in   = (cart_clk && !cart_rd_n && scnt == P - 1) ? rom_f(cart_addr) : 8'hFF;
  assign cart_data_in_1 = (cart_clk_1 && !cart_rd_n_1) ? rom_f(cart_addr_1) : 8'hFF;

  int n_pass = 0, n_total = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Transaction model: off = cycles since acceptance (0 = idle).
  int          off = 0;
  logic        m_we = 1'b0;
  logic [15:0] m_addr = 16'd0;
  logic [7:0]  m_wdata = 8'd0, m_rdata = 8'd0;
`ifdef CART_BUS_MASTER_BANK_SHADOW_EN
  logic [4:0]  m_shadow = 5'd1;
`endif

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      off <= 0;
      m_rdata <= 8'h00;
`ifdef CART_BUS_MASTER_BANK_SHADOW_EN
      m_shadow <= 5'd1;
`endif
    end else begin
      if (off == 0) begin
        if (req_valid) begin
          off <= 1; m_we <= req_we; m_addr <= req_addr; m_wdata <= req_wdata;
        end
      end else if (off == RESP_OFF) begin
        off <= 0;
`ifdef CART_BUS_MASTER_BANK_SHADOW_EN
        if (m_we && m_addr >= 16'h2000 && m_addr <= 16'h3FFF)
          m_shadow <= (m_wdata[4:0] == 5'd0) ? 5'd1 : m_wdata[4:0];
`endif
      end else begin
        off <= off + 1;
      end
      if (off == 3 * P) m_rdata <= m_we ? 8'h00 : rom_f(m_addr);
    end
  end

  always @(negedge clk) begin : cmp
    logic busy;
    int   ph;
    busy = (off >= 1 && off <= 3 * P);
    ph   = busy ? (off - 1) / P : 3;
    chk("req_ready", req_ready, off == 0);
    chk("rsp_valid", rsp_valid, off == RESP_OFF);
    chk("rsp_rdata", rsp_rdata, m_rdata);
    chk("cart_clk", cart_clk, ph == 1);
    chk("cart_rd_n", cart_rd_n, !(busy && !m_we && ph <= 1));
    chk("cart_wr_n", cart_wr_n, !(busy && m_we && ph == 1));
    chk("cart_data_oe", cart_data_oe, busy && m_we);
    chk("cart_cs_n", cart_cs_n, !(busy && m_addr >= 16'hA000 && m_addr <= 16'hBFFF));
    if (busy && m_we) chk("cart_data_out", cart_data_out, m_wdata);
    if (busy) chk("cart_addr", cart_addr, m_addr);
    else if (off == 0) chk("cart_addr_idle", cart_addr, 16'h0000);
`ifdef CART_BUS_MASTER_BANK_SHADOW_EN
    chk("bank_shadow", bank_shadow, m_shadow);
`endif
  end

  // One access on the main DUT; returns latency and strobe tallies.
  task automatic access(input logic we, input logic [15:0] a, input logic [7:0] d,
                        output int lat, output int rdl, output int wrl, output int csl, output int bad);
    int n;
    lat = 0; rdl = 0; wrl = 0; csl = 0; bad = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (off != 1 && n < 50);
    chk("accept_in_time", n < 50, 1'b1);
    // Scramble the request inputs: the DUT must use the registered copy.
    req_valid = 1'b0; req_we = ~we; req_addr = 16'hDEAD; req_wdata = 8'hEE;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (!cart_rd_n) rdl++;
      if (!cart_wr_n) wrl++;
      if (!cart_cs_n) csl++;
      if (!cart_wr_n && !cart_data_oe) bad++;
      if (!cart_wr_n && !cart_rd_n) bad++;
    end while (!rsp_valid && n < 100);
    lat = n;
  endtask

  initial begin
    int lat, rdl, wrl, csl, bad, n, acc, hi, pulses;
    int acc_t[3];
    logic prev;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_rd_n", cart_rd_n, 1'b1);
    chk("reset_rdata", rsp_rdata, 8'h00);

    // Read 0x0150
    access(1'b0, 16'h0150, 8'h00, lat, rdl, wrl, csl, bad);
    chk("rd0150_latency", lat, RESP_OFF);
    chk("rd0150_rd_low", rdl, 2 * P);
    chk("rd0150_wr_low", wrl, 0);
    chk("rd0150_cs_low", csl, 0);
    chk("rd0150_data", rsp_rdata, 8'h3C);

    // Bank-select writes
    access(1'b1, 16'h3FFF, 8'h07, lat, rdl, wrl, csl, bad);
    @(posedge clk); #1;
`ifdef CART_BUS_MASTER_BANK_SHADOW_EN
    chk("shadow_07", bank_shadow, 5'd7);
`endif
    access(1'b1, 16'h2000, 8'h00, lat, rdl, wrl, csl, bad);
    chk("wr2000_wr_low", wrl, P);
    chk("wr2000_rd_low", rdl, 0);
    chk("wr2000_overlap", bad, 0);
    chk("wr2000_rdata", rsp_rdata, 8'h00);
    @(posedge clk); #1;
`ifdef CART_BUS_MASTER_BANK_SHADOW_EN
    chk("shadow_00_as_1", bank_shadow, 5'd1);
`endif
    access(1'b1, 16'h2000, 8'h05, lat, rdl, wrl, csl, bad);
    @(posedge clk); #1;
`ifdef CART_BUS_MASTER_BANK_SHADOW_EN
    chk("shadow_05", bank_shadow, 5'd5);
`endif
    access(1'b1, 16'h4000, 8'h09, lat, rdl, wrl, csl, bad);
    @(posedge clk); #1;
`ifdef CART_BUS_MASTER_BANK_SHADOW_EN
    chk("shadow_outside", bank_shadow, 5'd5);
`endif

    // External RAM select
    access(1'b0, 16'hA000, 8'h00, lat, rdl, wrl, csl, bad);
    chk("rdA000_cs_low", csl, 3 * P);
    chk("rdA000_data", rsp_rdata, 8'hCD);
    access(1'b0, 16'h7FFF, 8'h00, lat, rdl, wrl, csl, bad);
    chk("rd7FFF_cs_low", csl, 0);
    chk("rd7FFF_data", rsp_rdata, 8'hED);

    // Back-to-back reads with req_valid held high
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0100;
    acc = 0; hi = 0; pulses = 0; prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (off == 1 && acc < 3) begin
        acc_t[acc] = i; acc++;
        if (acc == 3) req_valid = 1'b0;
        else req_addr = req_addr + 16'h1;
      end
      if (rsp_valid) hi++;
      if (rsp_valid && !prev) pulses++;
      prev = rsp_valid;
    end
    chk("b2b_accepts", acc, 3);
    chk("b2b_gap0", acc_t[1] - acc_t[0], 3 * P + 2);
    chk("b2b_gap1", acc_t[2] - acc_t[1], 3 * P + 2);
    chk("b2b_rsp_pulses", pulses, 3);
    chk("b2b_rsp_high_cycles", hi, 3);

    // PHASE_CLKS=1 instance, read 0x4000 (idle, so accepted at the next edge)
    @(posedge clk); #1;
    req_valid_1 = 1'b1; req_we_1 = 1'b0; req_addr_1 = 16'h4000;
    @(posedge clk); #1;
    req_valid_1 = 1'b0; req_addr_1 = 16'h0000;
    n = 0; rdl = 0;
    do begin
      @(negedge clk); n++;
      if (!cart_rd_n_1) rdl++;
    end while (!rsp_valid_1 && n < 20);
    chk("p1_latency", n, 4);
    chk("p1_rd_low", rdl, 2);
    chk("p1_data", rsp_rdata_1, 8'h2D);
    @(negedge clk);
    chk("p1_rsp_single", rsp_valid_1, 1'b0);
    chk("p1_ready_again", req_ready_1, 1'b1);

    // Reset during the STROBE of a write
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h3000; req_wdata = 8'h11;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (off != 1 && n < 50);
    req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (cart_wr_n && n < 50);
    chk("rst_reach_strobe", cart_wr_n, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("rst_wr_n_release", cart_wr_n, 1'b1);
    chk("rst_oe_release", cart_data_oe, 1'b0);
    chk("rst_cs_n_release", cart_cs_n, 1'b1);
    chk("rst_clk_release", cart_clk, 1'b0);
    hi = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #3 rst = 1'b1;
    @(negedge clk);
    chk("rst_ready_after", req_ready, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) hi++;
    end
    chk("rst_no_rsp", hi, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
